data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the single-cycle core's data-memory port: accepts the core's address, write enable and store data, and returns load data in the same cycle. Behind the port sit a word-addressed data RAM, a free-running cycle timer and a transmit FIFO that drains store data to an external consumer over a valid/ready handshake. Sits beside the processor in the top level, wired to its `mem_write`, `alu_result`, `write_data` and `read_data` signals.

## Interface
- `DEPTH_WORDS`, 256: data RAM size in 32-bit words; power of two, at most 1024.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2 to 16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  store enable from the core.
- `addr`  in  32  byte address from the core (ALU result).
- `write_data`  in  32  store data from the core.
- `read_data`  out  32  load data to the core; combinational from `addr`.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_data`  out  32  FIFO head entry.
- `tx_ready`  in  1  consumer accepts the head entry.

## Operation
- **Address bits**
  - `addr[1:0]` is ignored; all accesses are whole words.
- **Address map**
  - RAM: `0x0000_0000` to `DEPTH_WORDS*4-1`. Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
  - TX_DATA, `0x0000_1000`:
    - Write pushes `write_data` into the FIFO.
    - Read returns 0.
  - STATUS, `0x0000_1004`:
    - Read returns: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count. All other bits are 0.
    - Any write clears overflow.
  - TIMER, `0x0000_1008`:
    - Read returns the counter.
    - Write loads `write_data` into it.
  - Any other address: reads return 0, writes are ignored.
- **RAM**
  - Asynchronous read.
  - Write on the rising edge when `mem_write` is high and the address is in RAM range.
  - Contents are not reset.
- **Timer**
  - 32 bits; increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
  - A write has priority over the increment in that cycle.
- **FIFO**
  - Push: a TX_DATA write.
  - Pop: `tx_valid && tx_ready` at the edge.
  - Count width is `log2(FIFO_DEPTH)+1`.
  - Push while full with no pop in the same cycle: data is dropped, overflow is set, count is unchanged.
  - Push while full with a simultaneous pop: push is accepted, count is unchanged.
  - Push and pop together at other fill levels: count is unchanged.
  - Pop while empty cannot happen, because `tx_valid` is low.
- **Handshake**
  - Once `tx_valid` rises it stays high until the entry is popped.
  - `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.

## Timing
- **Reset values:**
  - timer 0
  - FIFO empty (count 0)
  - overflow 0
  - `tx_valid` 0
  - `tx_data` 0
- **`read_data`** is purely combinational: zero-cycle latency, as the single-cycle core requires. Reset does not gate it.
- **Store visibility:** a store at edge N is visible to a load in cycle N+1.
- **Push to head:**
  - There is no push-to-head bypass. A push into an empty FIFO at edge N raises `tx_valid` in cycle N+1 with the pushed data on `tx_data`.
  - STATUS reads the new count in cycle N+1.
- **Timer write:** a TIMER write at edge N reads back `write_data` in cycle N+1 and `write_data+1` in cycle N+2.
- **Overflow:** the bit sets at the edge of the dropped push.
  - If a STATUS write and a dropped push occur at the same edge, the set wins.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH`.
- **Reset mid-operation:** asynchronous assertion immediately empties the FIFO, zeroes the timer and clears overflow. RAM is kept.

## Structure
- Package `mem_map_pkg`:
  - constants `TX_DATA_ADDR`, `STATUS_ADDR`, `TIMER_ADDR`
  - STATUS bit positions
  - the `addr_region_t` enum (RAM, TX, STATUS, TIMER, NONE)
- Sub-module `sync_fifo`:
  - parameters `WIDTH`, `DEPTH`
  - ports `push`/`pop`/`din`/`dout`/`full`/`empty`/`count`
  - async active-low reset
- Top level contains:
  - the address decoder
  - the RAM array
  - the timer
  - the overflow flag
  - the read mux

## Test plan
- **Reset:** after reset release, read STATUS → `0x0000_0002`; read TIMER twice on consecutive cycles → 0 then 1; `tx_valid` = 0.
- **RAM:**
  - Store `0xDEAD_BEEF` to `0x0000_0040`, then load → `0xDEAD_BEEF` on the next cycle.
  - Load from `0x0000_0043` returns the same word.
  - Load from `0x0000_2000` → 0.
- **FIFO fill and drain:**
  - With `tx_ready` = 0, push 1, 2, 3, 4 → STATUS `0x0000_0041`.
  - A fifth push of 5 → STATUS `0x0000_0045` (overflow set).
  - Raise `tx_ready` → `tx_data` 1, 2, 3, 4 on successive cycles, then `tx_valid` = 0.
  - A write to STATUS clears overflow.
- **Full with simultaneous events:**
  - FIFO full, `tx_ready` = 1, push `0xAA` in the same cycle → count stays 4, overflow stays 0, `0xAA` emerges fifth.
- **Backpressure:** toggle `tx_ready` randomly over 100 pushes of an incrementing pattern → the output sequence matches in order, with no duplicates or losses, and `tx_data` is stable while stalled.
- **Timer and reset:**
  - Write `0xFFFF_FFFE` to TIMER → reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000` on successive cycles.
  - Assert `reset` mid-drain with FIFO count 3 → `tx_valid` drops immediately, and a RAM word written before reset is still readable afterwards.

Source files
------------

// File: rtl/mem_map_pkg.sv
// ---------------------------------------------------------------------------
// mem_map_pkg
// Shared address map for the data-memory responder: the fixed MMIO register
// addresses, the bit layout of the STATUS word and the region decoder used by
// the responder to steer every access to RAM, the TX FIFO, STATUS or TIMER.
// ---------------------------------------------------------------------------
package mem_map_pkg;

    // Memory-mapped register byte addresses (word aligned)
    localparam logic [31:0] TX_DATA_ADDR = 32'h0000_1000;
    localparam logic [31:0] STATUS_ADDR  = 32'h0000_1004;
    localparam logic [31:0] TIMER_ADDR   = 32'h0000_1008;

    // STATUS word layout
    localparam int STATUS_FULL_BIT     = 0;
    localparam int STATUS_EMPTY_BIT    = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_COUNT_LSB    = 4;
    localparam int STATUS_COUNT_MSB    = 8;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_TX,
        REGION_STATUS,
        REGION_TIMER,
        REGION_NONE
    } addr_region_t;

    // Classifies a byte address. The two low address bits never take part in
    // register matching, and the RAM limit is a multiple of four, so any byte
    // offset inside a word lands in the same region as the word itself.
    function automatic addr_region_t decodeRegion(input logic [31:0] byteAddr,
                                                  input logic [31:0] depthWords);
        addr_region_t region;
        logic [31:0]  ramLimit;
        ramLimit = {depthWords[29:0], 2'b00};
        region   = REGION_NONE;
        if (byteAddr < ramLimit) begin
            region = REGION_RAM;
        end else if (byteAddr[31:2] == TX_DATA_ADDR[31:2]) begin
            region = REGION_TX;
        end else if (byteAddr[31:2] == STATUS_ADDR[31:2]) begin
            region = REGION_STATUS;
        end else if (byteAddr[31:2] == TIMER_ADDR[31:2]) begin
            region = REGION_TIMER;
        end
        return region;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with power-of-two depth. A push while full is accepted
// only when a pop happens at the same edge; otherwise it is dropped and the
// caller is expected to notice via 'full'. Pops while empty are ignored.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low reset (empties the FIFO)
//   push   in   write 'din' at the next edge
//   pop    in   remove the head entry at the next edge
//   din    in   WIDTH  data to push
//   dout   out  WIDTH  head entry (0 while empty)
//   full   out  all DEPTH entries occupied
//   empty  out  no entries occupied
//   count  out  log2(DEPTH)+1 bits, number of occupied entries
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pushAccept;
    logic             popAccept;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign count = count_q;

    // Head is gated while empty so the output reads 0 out of reset even
    // though the storage array itself is never cleared.
    assign dout = empty ? '0 : storage_q[rdPtr_q];

    // A full FIFO can still take a push when the head leaves at the same edge.
    assign popAccept  = pop && !empty;
    assign pushAccept = push && (!full || popAccept);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushAccept) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popAccept) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushAccept, popAccept})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; stale entries are never visible through dout
    always_ff @(posedge clk) begin
        if (pushAccept) begin
            storage_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Responder side of the single-cycle core's data-memory port. Decodes the
// core's byte address into a word-addressed RAM, a TX FIFO push register, a
// STATUS register and a free-running cycle timer. Loads are combinational so
// the core sees read data in the same cycle it presents the address.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   mem_write   in   store enable from the core
//   addr        in   32  byte address (ALU result); bits [1:0] ignored
//   write_data  in   32  store data
//   read_data   out  32  load data, combinational from addr
//   tx_valid    out  TX FIFO holds at least one entry
//   tx_data     out  32  TX FIFO head entry
//   tx_ready    in   consumer takes the head entry at the next edge
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int RAM_AW  = $clog2(DEPTH_WORDS);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    addr_region_t        region;
    logic [RAM_AW-1:0]   ramIndex;
    logic [31:0]         ram_q [DEPTH_WORDS];
    logic [31:0]         timer_q, timer_d;
    logic                overflow_q, overflow_d;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [FIFO_CW-1:0]  fifoCount;
    logic [31:0]         statusWord;
    logic                droppedPush;

    assign region   = decodeRegion(addr, 32'(DEPTH_WORDS));
    assign ramIndex = addr[RAM_AW+1:2];

    assign fifoPush = mem_write && (region == REGION_TX);
    assign fifoPop  = tx_ready && !fifoEmpty;
    assign tx_valid = !fifoEmpty;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_txFifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (write_data),
        .dout  (tx_data),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // A push is lost only when the FIFO is full and nothing leaves this edge
    assign droppedPush = fifoPush && fifoFull && !fifoPop;

    // Assemble the STATUS word from live FIFO flags and the sticky overflow
    always_comb begin
        statusWord                                       = '0;
        statusWord[STATUS_FULL_BIT]                      = fifoFull;
        statusWord[STATUS_EMPTY_BIT]                     = fifoEmpty;
        statusWord[STATUS_OVERFLOW_BIT]                  = overflow_q;
        statusWord[STATUS_COUNT_MSB:STATUS_COUNT_LSB]    = 5'(fifoCount);
    end

    // Load path; deliberately independent of reset so the core can always read
    always_comb begin
        read_data = '0;
        case (region)
            REGION_RAM:    read_data = ram_q[ramIndex];
            REGION_TX:     read_data = '0;
            REGION_STATUS: read_data = statusWord;
            REGION_TIMER:  read_data = timer_q;
            default:       read_data = '0;
        endcase
    end

    // Overflow: any STATUS write clears it, but a dropped push in the same
    // cycle sets it, so the set is evaluated last
    always_comb begin
        overflow_d = overflow_q;
        if (mem_write && (region == REGION_STATUS)) begin
            overflow_d = 1'b0;
        end
        if (droppedPush) begin
            overflow_d = 1'b1;
        end
    end

    // Timer free-runs and wraps; a software load replaces that cycle's increment
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (mem_write && (region == REGION_TIMER)) begin
            timer_d = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    // RAM contents survive reset, so this array has no reset branch
    always_ff @(posedge clk) begin
        if (mem_write && (region == REGION_RAM)) begin
            ram_q[ramIndex] <= write_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder. A directed vector table walks
// through reset, RAM, FIFO fill/drain/overflow and timer wrap; a randomized
// phase exercises backpressure against a queue-based reference model; a
// final hand-written sequence asserts reset in the middle of a drain.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int FD          = 4;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state, expressed as plain containers
    logic [31:0] ramModel [int];
    logic [31:0] fifoM [$];
    bit          ovfM;
    logic [31:0] timerM;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rdy;
        bit          chkRead;
        logic [31:0] expRead;
        bit          expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [$];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls the main sequence
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Predicted load value from the model; returns 0 when the RAM word is unknown
    function automatic bit expectRead(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] word;
        word = a & ~32'h3;
        v    = 32'h0;
        if (a < DEPTH_WORDS * 4) begin
            if (ramModel.exists(int'(a >> 2))) begin
                v = ramModel[int'(a >> 2)];
                return 1'b1;
            end
            return 1'b0;
        end
        if (word == 32'h1004) begin
            v = 32'(fifoM.size() == FD)
              | (32'(fifoM.size() == 0) << 1)
              | (32'(ovfM) << 2)
              | (32'(fifoM.size()) << 4);
        end else if (word == 32'h1008) begin
            v = timerM;
        end
        return 1'b1;
    endfunction

    // Apply the rules for one rising edge given the inputs presented this cycle
    task automatic modelStep(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        logic [31:0] word;
        bit popM, pushM, dropped;
        word    = a & ~32'h3;
        popM    = (fifoM.size() > 0) && rdy;
        pushM   = we && (word == 32'h1000);
        dropped = pushM && (fifoM.size() == FD) && !popM;
        if (popM) void'(fifoM.pop_front());
        if (pushM && !dropped) fifoM.push_back(wd);
        if (we && word == 32'h1004) ovfM = 1'b0;
        if (dropped) ovfM = 1'b1;
        if (we && word == 32'h1008) timerM = wd;
        else timerM = timerM + 32'd1;
        if (we && a < DEPTH_WORDS * 4) ramModel[int'(a >> 2)] = wd;
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        mem_write  = we;
        addr       = a;
        write_data = wd;
        tx_ready   = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expV;
        bit known;
        known = expectRead(addr, expV);
        if (known) checkVal({tag, ".read_data"}, read_data, expV);
        checkVal({tag, ".tx_valid"}, 32'(tx_valid), 32'(fifoM.size() > 0));
        checkVal({tag, ".tx_data"}, tx_data, (fifoM.size() > 0) ? fifoM[0] : 32'h0);
    endtask

    task automatic advance();
        modelStep(mem_write, addr, write_data, tx_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void addVec(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                   input bit rdy, input bit cr, input logic [31:0] er,
                                   input bit ev, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.rdy = rdy;
        v.chkRead = cr; v.expRead = er; v.expValid = ev; v.expData = ed;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] rcvQ [$];
        logic [31:0] prevData;
        bit          prevStall;
        int          sent;
        int          cycles;
        int          op;
        bit          doPush;
        logic [31:0] rAddr;

        reset      = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        tx_ready   = 1'b0;
        ovfM       = 1'b0;
        timerM     = 32'h0;
        #2;
        checkVal("reset.tx_valid", 32'(tx_valid), 32'h0);
        checkVal("reset.tx_data", tx_data, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // we, addr, wdata, rdy, chkRead, expRead, expValid, expData
        addVec(0, 32'h1008, 0, 0, 1, 32'h0, 0, 0);
        addVec(0, 32'h1008, 0, 0, 1, 32'h1, 0, 0);
        addVec(0, 32'h1004, 0, 0, 1, 32'h2, 0, 0);
        addVec(1, 32'h0040, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        addVec(0, 32'h0040, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        addVec(0, 32'h0043, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        addVec(0, 32'h2000, 0, 0, 1, 32'h0, 0, 0);
        addVec(1, 32'h1000, 32'h1, 0, 1, 32'h0, 0, 0);
        addVec(1, 32'h1000, 32'h2, 0, 1, 32'h0, 1, 32'h1);
        addVec(1, 32'h1000, 32'h3, 0, 1, 32'h0, 1, 32'h1);
        addVec(1, 32'h1000, 32'h4, 0, 1, 32'h0, 1, 32'h1);
        addVec(0, 32'h1004, 0, 0, 1, 32'h41, 1, 32'h1);
        addVec(1, 32'h1000, 32'h5, 0, 1, 32'h0, 1, 32'h1);
        addVec(0, 32'h1004, 0, 0, 1, 32'h45, 1, 32'h1);
        addVec(0, 32'h1004, 0, 1, 1, 32'h45, 1, 32'h1);
        addVec(0, 32'h1004, 0, 1, 1, 32'h34, 1, 32'h2);
        addVec(0, 32'h1004, 0, 1, 1, 32'h24, 1, 32'h3);
        addVec(0, 32'h1004, 0, 1, 1, 32'h14, 1, 32'h4);
        addVec(0, 32'h1004, 0, 0, 1, 32'h06, 0, 0);
        addVec(1, 32'h1004, 0, 0, 1, 32'h06, 0, 0);
        addVec(0, 32'h1004, 0, 0, 1, 32'h02, 0, 0);
        addVec(1, 32'h1000, 32'h11, 0, 1, 32'h0, 0, 0);
        addVec(1, 32'h1000, 32'h22, 0, 1, 32'h0, 1, 32'h11);
        addVec(1, 32'h1000, 32'h33, 0, 1, 32'h0, 1, 32'h11);
        addVec(1, 32'h1000, 32'h44, 0, 1, 32'h0, 1, 32'h11);
        addVec(1, 32'h1000, 32'hAA, 1, 1, 32'h0, 1, 32'h11);
        addVec(0, 32'h1004, 0, 0, 1, 32'h41, 1, 32'h22);
        addVec(0, 32'h1004, 0, 1, 1, 32'h41, 1, 32'h22);
        addVec(0, 32'h1004, 0, 1, 1, 32'h30, 1, 32'h33);
        addVec(0, 32'h1004, 0, 1, 1, 32'h20, 1, 32'h44);
        addVec(0, 32'h1004, 0, 1, 1, 32'h10, 1, 32'hAA);
        addVec(0, 32'h1004, 0, 0, 1, 32'h02, 0, 0);
        addVec(1, 32'h1008, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        addVec(0, 32'h1008, 0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        addVec(0, 32'h1008, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        addVec(0, 32'h1008, 0, 0, 1, 32'h0000_0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            if (vecs[i].chkRead)
                checkVal($sformatf("vec%0d.read_data", i), read_data, vecs[i].expRead);
            checkVal($sformatf("vec%0d.tx_valid", i), 32'(tx_valid), 32'(vecs[i].expValid));
            checkVal($sformatf("vec%0d.tx_data", i), tx_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d.model", i));
            advance();
        end

        // Randomized backpressure with interleaved RAM/STATUS/TIMER traffic
        sent      = 0;
        cycles    = 0;
        prevStall = 1'b0;
        prevData  = 32'h0;
        while ((sent < 100 || fifoM.size() > 0) && cycles < 3000) begin
            doPush = (sent < 100) && (fifoM.size() < FD) && ($urandom_range(0, 1) == 1);
            if (doPush) begin
                applyStimulus(1, 32'h1000, 32'h5000_0000 + 32'(sent), $urandom_range(0, 1) == 1);
                sent++;
            end else begin
                op    = $urandom_range(0, 3);
                rAddr = 32'($urandom_range(0, DEPTH_WORDS * 4 - 1));
                case (op)
                    0: applyStimulus(0, rAddr, 0, $urandom_range(0, 1) == 1);
                    1: applyStimulus(1, rAddr, $urandom, $urandom_range(0, 1) == 1);
                    2: applyStimulus(0, 32'h1004, 0, $urandom_range(0, 1) == 1);
                    default: applyStimulus(0, 32'h1008, 0, $urandom_range(0, 1) == 1);
                endcase
            end
            checkOutput($sformatf("bp%0d", cycles));
            if (prevStall) begin
                checkVal("bp.stall_valid", 32'(tx_valid), 32'h1);
                checkVal("bp.stall_data", tx_data, prevData);
            end
            if (tx_valid && tx_ready) rcvQ.push_back(tx_data);
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
            advance();
            cycles++;
        end
        checkVal("bp.finished", 32'(cycles < 3000), 32'h1);
        checkVal("bp.count", 32'(rcvQ.size()), 32'd100);
        for (int i = 0; i < rcvQ.size() && i < 100; i++)
            checkVal($sformatf("bp.order%0d", i), rcvQ[i], 32'h5000_0000 + 32'(i));

        // Reset asserted in the middle of a drain
        applyStimulus(1, 32'h0080, 32'h1234_5678, 0);
        checkOutput("rst.ramwr");
        advance();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h1000, 32'hC000_0000 + 32'(k), 0);
            checkOutput($sformatf("rst.push%0d", k));
            advance();
        end
        applyStimulus(0, 32'h1004, 0, 1);
        checkVal("rst.status_full", read_data, 32'h41);
        checkOutput("rst.pop");
        advance();
        applyStimulus(0, 32'h1004, 0, 1);
        checkVal("rst.status_count3", read_data, 32'h30);
        checkVal("rst.valid_before", 32'(tx_valid), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        fifoM.delete();
        ovfM   = 1'b0;
        timerM = 32'h0;
        checkVal("rst.valid_drop", 32'(tx_valid), 32'h0);
        checkVal("rst.data_zero", tx_data, 32'h0);
        checkVal("rst.status", read_data, 32'h2);
        addr = 32'h1008;
        #1;
        checkVal("rst.timer_zero", read_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 32'h0080, 0, 0);
        checkVal("rst.ram_kept", read_data, 32'h1234_5678);
        checkOutput("rst.after0");
        advance();
        applyStimulus(0, 32'h1008, 0, 0);
        checkVal("rst.timer_run", read_data, 32'h1);
        checkOutput("rst.after1");
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
